// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared types and helpers for memory-port arbiters
package bus_pkg;

  localparam int unsigned BUS_AW = 32;
  localparam int unsigned BUS_DW = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_INSTR = 2'd1,
    ST_DATA  = 2'd2,
    ST_DROP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWNER_INSTR = 1'b0,
    OWNER_DATA  = 1'b1
  } arb_owner_t;

  // Return data only while its response qualifier is high, zero otherwise.
  function automatic logic [BUS_DW-1:0] gate_data(input logic en, input logic [BUS_DW-1:0] d);
    return en ? d : '0;
  endfunction

endpackage

// File: rtl/core_bus_arbiter_if.sv
// rtl/core_bus_arbiter_if.sv - core fetch/data buses and memory port seen by the arbiter
interface core_bus_arbiter_if;
  import bus_pkg::*;

  logic              instr_req_i;
  logic              instr_flush_i;
  logic [BUS_AW-1:0] instr_addr_i;
  logic              instr_rsp_o;
  logic [BUS_DW-1:0] instr_data_o;

  logic              data_rd_i;
  logic              data_wr_i;
  logic [BUS_AW-1:0] data_addr_i;
  logic [BUS_DW-1:0] data_wdata_i;
  logic              data_rsp_o;
  logic [BUS_DW-1:0] data_rdata_o;

  logic              mem_rd_o;
  logic              mem_wr_o;
  logic [BUS_AW-1:0] mem_addr_o;
  logic [BUS_DW-1:0] mem_wdata_o;
  logic              mem_ack_i;
  logic [BUS_DW-1:0] mem_rdata_i;

  logic              bus_timeout_o;

  modport slave (
    input  instr_req_i, instr_flush_i, instr_addr_i,
    input  data_rd_i, data_wr_i, data_addr_i, data_wdata_i,
    input  mem_ack_i, mem_rdata_i,
    output instr_rsp_o, instr_data_o,
    output data_rsp_o, data_rdata_o,
    output mem_rd_o, mem_wr_o, mem_addr_o, mem_wdata_o,
    output bus_timeout_o
  );

  modport master (
    output instr_req_i, instr_flush_i, instr_addr_i,
    output data_rd_i, data_wr_i, data_addr_i, data_wdata_i,
    output mem_ack_i, mem_rdata_i,
    input  instr_rsp_o, instr_data_o,
    input  data_rsp_o, data_rdata_o,
    input  mem_rd_o, mem_wr_o, mem_addr_o, mem_wdata_o,
    input  bus_timeout_o
  );

endinterface

// File: rtl/bus_watchdog.sv
// rtl/bus_watchdog.sv - cycle counter flagging a transaction that outlived its budget
module bus_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

  logic [CW-1:0] cnt_q, cnt_d;

  // The count equals the number of enabled cycles already spent, so the
  // budget expires during the TIMEOUT_CYCLES-th enabled cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (TIMEOUT_CYCLES != 0) && enable_i && (cnt_q == LAST);

endmodule

// File: rtl/core_bus_arbiter.sv
// rtl/core_bus_arbiter.sv - round-robin arbiter sharing one memory port between fetch and data buses
module core_bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  core_bus_arbiter_if.slave bus
);

  arb_state_t        state_q, state_d;
  arb_owner_t        last_grant_q, last_grant_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mem_wr_q, mem_wr_d;
  logic [BUS_AW-1:0] mem_addr_q, mem_addr_d;
  logic [BUS_DW-1:0] mem_wdata_q, mem_wdata_d;

  logic instr_pend;
  logic data_pend;
  logic grant;
  logic wd_busy;
  logic wd_expired;
  logic instr_rsp;
  logic data_rsp;
  logic instr_fwd;
  logic data_fwd;
  logic timeout;

  assign instr_pend = bus.instr_req_i & ~bus.instr_flush_i;
  assign data_pend  = bus.data_rd_i | bus.data_wr_i;
  assign wd_busy    = (state_q != ST_IDLE);

  bus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (grant),
    .enable_i (wd_busy),
    .expired_o(wd_expired)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    mem_rd_d     = mem_rd_q;
    mem_wr_d     = mem_wr_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    grant        = 1'b0;
    instr_rsp    = 1'b0;
    data_rsp     = 1'b0;
    instr_fwd    = 1'b0;
    data_fwd     = 1'b0;
    timeout      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // On a tie the side that did not win last time gets the port.
        if (instr_pend && (!data_pend || (last_grant_q == OWNER_DATA))) begin
          grant        = 1'b1;
          state_d      = ST_INSTR;
          last_grant_d = OWNER_INSTR;
          mem_rd_d     = 1'b1;
          mem_wr_d     = 1'b0;
          mem_addr_d   = bus.instr_addr_i;
        end else if (data_pend) begin
          grant        = 1'b1;
          state_d      = ST_DATA;
          last_grant_d = OWNER_DATA;
          mem_rd_d     = ~bus.data_wr_i;
          mem_wr_d     = bus.data_wr_i;
          mem_addr_d   = bus.data_addr_i;
          mem_wdata_d  = bus.data_wdata_i;
        end
      end

      ST_INSTR: begin
        if (bus.mem_ack_i) begin
          state_d   = ST_IDLE;
          mem_rd_d  = 1'b0;
          mem_wr_d  = 1'b0;
          instr_rsp = ~bus.instr_flush_i;
          instr_fwd = ~bus.instr_flush_i;
        end else if (wd_expired) begin
          state_d   = ST_IDLE;
          mem_rd_d  = 1'b0;
          mem_wr_d  = 1'b0;
          timeout   = 1'b1;
          instr_rsp = ~bus.instr_flush_i;
        end else if (bus.instr_flush_i) begin
          state_d = ST_DROP;
        end
      end

      // A cancelled fetch keeps its strobe so the memory still sees a whole transaction.
      ST_DROP: begin
        if (bus.mem_ack_i || wd_expired) begin
          state_d  = ST_IDLE;
          mem_rd_d = 1'b0;
          mem_wr_d = 1'b0;
          timeout  = ~bus.mem_ack_i;
        end
      end

      ST_DATA: begin
        if (bus.mem_ack_i) begin
          state_d  = ST_IDLE;
          mem_rd_d = 1'b0;
          mem_wr_d = 1'b0;
          data_rsp = 1'b1;
          data_fwd = 1'b1;
        end else if (wd_expired) begin
          state_d  = ST_IDLE;
          mem_rd_d = 1'b0;
          mem_wr_d = 1'b0;
          timeout  = 1'b1;
          data_rsp = 1'b1;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        mem_rd_d = 1'b0;
        mem_wr_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= OWNER_DATA;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      mem_rd_q     <= mem_rd_d;
      mem_wr_q     <= mem_wr_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign bus.mem_rd_o      = mem_rd_q;
  assign bus.mem_wr_o      = mem_wr_q;
  assign bus.mem_addr_o    = mem_addr_q;
  assign bus.mem_wdata_o   = mem_wdata_q;
  assign bus.instr_rsp_o   = instr_rsp;
  assign bus.data_rsp_o    = data_rsp;
  assign bus.instr_data_o  = gate_data(instr_fwd, bus.mem_rdata_i);
  assign bus.data_rdata_o  = gate_data(data_fwd, bus.mem_rdata_i);
  assign bus.bus_timeout_o = timeout;

endmodule
